parity_stream: RTL and testbench

- Bit-serial parity generator/checker for UPDI-style UART frames (e.g. 8E2). It is the sequential, runtime-configurable successor of the combinational parity calculator.
- It accumulates parity over BITS data bits as they arrive one per strobe.
- It presents the expected parity bit for the TX path.
- It optionally consumes the received parity bit and flags mismatches for the RX path.
- It keeps a saturating error counter for link diagnostics.

---
 rtl/updi_pkg.sv | 17 +
 rtl/parity_stream_if.sv | 29 ++
 rtl/err_counter_sat.sv | 22 ++
 rtl/parity_stream.sv | 125 ++++++++++++
 tb/tb_parity_stream.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/updi_pkg.sv
// Shared UPDI link types: parity mode encoding and the parity FSM state set.
package updi_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } parity_mode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_DATA  = 2'b01,
    S_CHECK = 2'b10
  } state_t;

endpackage

// File: rtl/parity_stream_if.sv
// Control/strobe inputs and status outputs of the serial parity engine.
// Strobe semantics: bit_in is consumed on every rising edge where bit_valid is
// high (there is no back-pressure); start is a one-cycle pulse that wins over
// a coincident bit_valid.
interface parity_stream_if #(
  parameter int ERR_CNT_W = 8
);
  logic [1:0]           mode;
  logic                 start;
  logic                 bit_valid;
  logic                 bit_in;
  logic                 clr_count;
  logic                 busy;
  logic                 parity_out;
  logic                 parity_valid;
  logic                 done;
  logic                 parity_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output mode, start, bit_valid, bit_in, clr_count,
    input  busy, parity_out, parity_valid, done, parity_err, err_count
  );

  modport slave (
    input  mode, start, bit_valid, bit_in, clr_count,
    output busy, parity_out, parity_valid, done, parity_err, err_count
  );
endinterface

// File: rtl/err_counter_sat.sv
// Saturating event counter with synchronous clear; clear beats a coincident increment.
module err_counter_sat #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/parity_stream.sv
// Bit-serial parity generator/checker for UART-style frames with a
// saturating mismatch counter; FSM state is exported on dbg_state.
module parity_stream
  import updi_pkg::*;
#(
  parameter int BITS      = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  parity_stream_if.slave   bus,
  output state_t           dbg_state
);

  localparam int            CW   = $clog2(BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  state_t        state_q, state_d;
  parity_mode_t  mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc_q, acc_d;
  logic          pout_q, pout_d;
  logic          pv_q, pv_d;
  logic          done_q, done_d;
  logic          perr_q, perr_d;
  logic          err_inc;
  logic          acc_next;

  assign acc_next = acc_q ^ bus.bit_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= PAR_NONE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      pout_q  <= 1'b0;
      pv_q    <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      pout_q  <= pout_d;
      pv_q    <= pv_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    pout_d  = pout_q;
    pv_d    = 1'b0;
    done_d  = 1'b0;
    perr_d  = perr_q;
    err_inc = 1'b0;
    if (bus.start) begin
      // Restart from any state; a coincident data/parity bit is dropped.
      // The reserved encoding behaves exactly like "none".
      if ((bus.mode == PAR_EVEN) || (bus.mode == PAR_ODD)) begin
        mode_d = parity_mode_t'(bus.mode);
      end else begin
        mode_d = PAR_NONE;
      end
      cnt_d   = '0;
      acc_d   = 1'b0;
      pout_d  = 1'b0;
      perr_d  = 1'b0;
      state_d = S_DATA;
    end else begin
      case (state_q)
        S_DATA: begin
          if (bus.bit_valid) begin
            acc_d = acc_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              if (mode_q == PAR_NONE) begin
                done_d  = 1'b1;
                perr_d  = 1'b0;
                state_d = S_IDLE;
              end else begin
                pout_d  = acc_next ^ (mode_q == PAR_ODD);
                pv_d    = 1'b1;
                state_d = S_CHECK;
              end
            end
          end
        end
        S_CHECK: begin
          if (bus.bit_valid) begin
            done_d  = 1'b1;
            perr_d  = (bus.bit_in != pout_q);
            err_inc = (bus.bit_in != pout_q);
            state_d = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  err_counter_sat #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.clr_count),
    .inc   (err_inc),
    .count (bus.err_count)
  );

  assign bus.busy         = (state_q != S_IDLE);
  assign bus.parity_out   = pout_q;
  assign bus.parity_valid = pv_q;
  assign bus.done         = done_q;
  assign bus.parity_err   = perr_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_parity_stream.sv
// Directed bench for parity_stream: frame-level reference model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_parity_stream;
  import updi_pkg::*;

  localparam int BITS  = 8;
  localparam int ECW   = 2;
  localparam int EMAX  = (1 << ECW) - 1;

  logic   clk;
  logic   rst;
  state_t dbg_state;

  parity_stream_if #(.ERR_CNT_W(ECW)) bus ();

  parity_stream #(.BITS(BITS), .ERR_CNT_W(ECW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_total  = 0;
  int n_passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Phase: 0 idle, 1 collecting data bits, 2 awaiting received parity.
  int   m_phase = 0;
  int   m_mode  = 0;
  logic m_bits[$];
  logic exp_busy = 0, exp_pv = 0, exp_done = 0, exp_pout = 0, exp_perr = 0;
  int   exp_cnt = 0;

  task automatic model_reset();
    m_phase = 0; m_mode = 0; m_bits.delete();
    exp_busy = 0; exp_pv = 0; exp_done = 0; exp_pout = 0; exp_perr = 0;
    exp_cnt = 0;
  endtask

  task automatic model_edge(input logic st, input logic [1:0] md, input logic bv,
                            input logic bi, input logic clr);
    int ones;
    logic err;
    err = 1'b0;
    exp_pv = 0; exp_done = 0;
    if (st) begin
      m_phase = 1;
      m_mode  = (md == 2'b01 || md == 2'b10) ? int'(md) : 0;
      m_bits.delete();
      exp_perr = 0; exp_pout = 0;
    end else if (m_phase == 1 && bv) begin
      m_bits.push_back(bi);
      if (m_bits.size() == BITS) begin
        if (m_mode == 0) begin
          exp_done = 1; exp_perr = 0; m_phase = 0;
        end else begin
          ones = 0;
          foreach (m_bits[k]) ones += int'(m_bits[k]);
          exp_pout = ((ones % 2) == 1) ^ (m_mode == 2);
          exp_pv = 1; m_phase = 2;
        end
      end
    end else if (m_phase == 2 && bv) begin
      exp_done = 1; err = (bi != exp_pout); exp_perr = err; m_phase = 0;
    end
    if (clr) exp_cnt = 0;
    else if (err && exp_cnt < EMAX) exp_cnt++;
    exp_busy = (m_phase != 0);
  endtask

  // ---------------- per-cycle compare ----------------
  int   seen_pv = 0, seen_done = 0;
  logic seen_pout = 0;

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", bus.busy, exp_busy);
      check("parity_valid", bus.parity_valid, exp_pv);
      check("done", bus.done, exp_done);
      check("parity_out", bus.parity_out, exp_pout);
      check("parity_err", bus.parity_err, exp_perr);
      check("err_count", bus.err_count, exp_cnt);
      check("no_pv_done_overlap", bus.parity_valid & bus.done, 0);
      if (bus.parity_valid) begin seen_pv++; seen_pout = bus.parity_out; end
      if (bus.done) seen_done++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic st, input logic [1:0] md, input logic bv,
                       input logic bi, input logic clr);
    bus.start = st; bus.mode = md; bus.bit_valid = bv; bus.bit_in = bi; bus.clr_count = clr;
    @(posedge clk);
    model_edge(st, md, bv, bi, clr);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 2'b00, 0, 0, 0);
  endtask

  task automatic frame(input logic [1:0] md, input logic [15:0] data, input int nbits,
                       input logic gaps, input logic send_par, input logic rx,
                       input logic clr_on_par);
    drive(1, md, 0, 0, 0);
    for (int i = 0; i < nbits; i++) begin
      if (gaps && (i % 3 == 1)) idle(2);
      drive(0, md, 1, data[i], 0);
    end
    if (send_par) drive(0, md, 1, rx, clr_on_par);
  endtask

  int pv0, dn0;

  initial begin
    rst = 1'b1;
    bus.start = 0; bus.mode = 0; bus.bit_valid = 0; bus.bit_in = 0; bus.clr_count = 0;
    #2;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_pv", bus.parity_valid, 0);
    check("rst_count", bus.err_count, 0);
    @(posedge clk); #1; rst = 1'b0;
    idle(2);

    // Even 0xA5, received parity 0
    pv0 = seen_pv; dn0 = seen_done;
    frame(2'b01, 16'h00A5, 8, 0, 1, 0, 0); idle(2);
    check("a5_pout", seen_pout, 0);
    check("a5_perr", bus.parity_err, 0);
    check("a5_count", bus.err_count, 0);
    check("a5_pv_pulses", seen_pv - pv0, 1);
    check("a5_done_pulses", seen_done - dn0, 1);

    // Odd 0x07, received parity 1 then 0 (with strobe gaps)
    frame(2'b10, 16'h0007, 8, 1, 1, 1, 0); idle(2);
    check("odd1_pout", seen_pout, 0);
    check("odd1_perr", bus.parity_err, 1);
    check("odd1_count", bus.err_count, 1);
    frame(2'b10, 16'h0007, 8, 0, 1, 0, 0); idle(2);
    check("odd0_perr", bus.parity_err, 0);
    check("odd0_count", bus.err_count, 1);

    // Mode none 0xFF, and reserved mode behaving as none
    pv0 = seen_pv; dn0 = seen_done;
    frame(2'b00, 16'h00FF, 8, 0, 0, 0, 0); idle(2);
    frame(2'b11, 16'h00FF, 8, 1, 0, 0, 0); idle(2);
    check("none_pv_pulses", seen_pv - pv0, 0);
    check("none_done_pulses", seen_done - dn0, 2);
    check("none_perr", bus.parity_err, 0);
    check("none_count", bus.err_count, 1);

    // Abort after 4 bits, then full even frame 0x01 with parity 1
    dn0 = seen_done;
    frame(2'b01, 16'h000F, 4, 0, 0, 0, 0);
    frame(2'b01, 16'h0001, 8, 0, 1, 1, 0); idle(2);
    check("abort_done_pulses", seen_done - dn0, 1);
    check("abort_pout", seen_pout, 1);
    check("abort_perr", bus.parity_err, 0);

    // TX-only frame: start in CHECK aborts without done or count
    dn0 = seen_done;
    frame(2'b01, 16'h0080, 8, 0, 0, 0, 0);
    idle(1);
    drive(1, 2'b01, 1, 1, 0);
    idle(3);
    check("tx_abort_pout", seen_pout, 1);
    check("tx_abort_done", seen_done - dn0, 0);
    check("tx_abort_count", bus.err_count, 1);

    // Saturation: clear, five erroneous frames, then clear during a sixth error
    drive(0, 2'b00, 0, 0, 1); idle(1);
    check("clr_count", bus.err_count, 0);
    for (int f = 0; f < 5; f++) begin
      frame(2'b01, 16'h0000, 8, 0, 1, 1, 0); idle(1);
      check("sat_count", bus.err_count, (f < 3) ? f + 1 : 3);
    end
    frame(2'b01, 16'h0000, 8, 0, 1, 1, 1); idle(1);
    check("sat_clr_wins", bus.err_count, 0);
    check("sat_clr_perr", bus.parity_err, 1);

    // Asynchronous reset between edges mid-frame
    frame(2'b01, 16'h0007, 3, 0, 0, 0, 0);
    #2; rst = 1'b1; #1;
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_pv", bus.parity_valid, 0);
    model_reset();
    bus.bit_valid = 0;
    @(posedge clk); #1; rst = 1'b0;
    frame(2'b01, 16'h0003, 8, 0, 1, 0, 0); idle(2);
    check("post_rst_pout", seen_pout, 0);
    check("post_rst_perr", bus.parity_err, 0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
